instruction_prefetch_buffer: RTL and testbench

Instruction prefetch stage between the word-addressed memory controller and the processor's decode stage. It generates opcode-fetch requests on the memory interface and buffers returned words in a DEPTH-entry FIFO. Each buffered word is tagged with its fetch address and abort status and presented to decode over a valid/ready handshake. A branch redirect flushes all buffered and in-flight words and restarts fetching at the target.

---
 rtl/instruction_prefetch_buffer.sv | 172 +++++++++++++++++
 tb/tb_instruction_prefetch_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch stage: issues opcode fetches and queues returned
// words, tagged with fetch address and abort status, for decode.
module instruction_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        n_reset,
  output logic [31:0] addr,
  output logic [1:0]  trans,
  output logic        write,
  output logic [1:0]  prot,
  input  logic [31:0] rdata,
  input  logic        abort,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_abort,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW+1:0] DEPTH_W = (PW + 2)'(DEPTH);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        abt;
  } entry_t;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    trans_q, trans_d;
  logic          first_q, first_d;
  logic          infl_q, infl_d;
  logic [31:0]   infl_addr_q, infl_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  entry_t        hold_q, hold_d;
  entry_t        mem_q [DEPTH];

  entry_t        head;
  entry_t        wr_entry;
  logic          vld;
  logic          push;
  logic          pop;
  logic          halt;
  logic          issue;
  logic [PW+1:0] occ;

  assign write = 1'b0;
  assign prot  = 2'b10;
  assign addr  = addr_q;
  assign trans = trans_q;

  // Empty FIFO keeps presenting the last head seen.
  always_comb begin
    head   = mem_q[rd_ptr_q];
    vld    = (count_q != '0);
    hold_d = vld ? head : hold_q;
  end

  assign instr_valid = vld;
  assign instr       = hold_d.word;
  assign instr_pc    = hold_d.pc;
  assign instr_abort = hold_d.abt;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trans_d     = trans_q;
    first_d     = first_q;
    infl_d      = 1'b0;
    infl_addr_d = addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    halt        = 1'b0;
    issue       = 1'b0;
    occ         = '0;
    push        = infl_q & ~branch_valid;
    pop         = vld & instr_ready & ~branch_valid;
    wr_entry    = '{word: rdata, pc: infl_addr_q, abt: abort};
    if (branch_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = S_FETCH;
      trans_d  = T_NSEQ;
      addr_d   = branch_target;
      first_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // An aborted word squashes the request issued alongside it.
      halt   = (state_q == S_HALT) | (infl_q & abort);
      infl_d = (trans_q != T_IDLE) & ~(infl_q & abort);
      occ    = {1'b0, count_d} + {{(PW + 1){1'b0}}, infl_d};
      issue  = ~halt & (occ < DEPTH_W);
      unique case (1'b1)
        halt: begin
          state_d = S_HALT;
          trans_d = T_IDLE;
        end
        issue: begin
          state_d = S_FETCH;
          trans_d = (state_q == S_FETCH) ? T_SEQ : T_NSEQ;
          addr_d  = first_q ? addr_q : addr_q + 32'd1;
          first_d = 1'b0;
        end
        default: begin
          state_d = S_WAIT;
          trans_d = T_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_WAIT;
      addr_q      <= RESET_PC;
      trans_q     <= T_IDLE;
      first_q     <= 1'b1;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trans_q     <= trans_d;
      first_q     <= first_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed bench for instruction_prefetch_buffer; the memory model
// returns word == address and can flag one address as aborting.
module tb_instruction_prefetch_buffer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        write;
  logic [1:0]  prot;
  logic [31:0] rdata;
  logic        abort;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_abort;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  logic        abort_en = 1'b0;
  logic [31:0] abort_addr = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  instruction_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .addr(addr),
    .trans(trans),
    .write(write),
    .prot(prot),
    .rdata(rdata),
    .abort(abort),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_abort(instr_abort),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    pend      = (trans != 2'b00);
    pend_addr = addr;
  end

  always @(posedge clk) begin
    #1;
    rdata = pend ? pend_addr : 32'hDEAD_BEEF;
    abort = pend && abort_en && (pend_addr == abort_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_reset       = 1'b0;
    instr_ready   = 1'b1;
    branch_valid  = 1'b0;
    branch_target = '0;
    rdata         = '0;
    abort         = 1'b0;

    // reset state
    step();
    step();
    chk("rst_trans", 32'(trans), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_prot", 32'(prot), 32'h2);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_abort", 32'(instr_abort), 32'h0);

    // streaming from reset
    n_reset = 1'b1;
    step();
    chk("s_c1_trans", 32'(trans), 32'h2);
    chk("s_c1_addr", addr, 32'h0);
    chk("s_c1_valid", 32'(instr_valid), 32'h0);
    step();
    chk("s_c2_trans", 32'(trans), 32'h3);
    chk("s_c2_addr", addr, 32'h1);
    chk("s_c2_valid", 32'(instr_valid), 32'h0);
    for (int c = 3; c <= 8; c++) begin
      step();
      chk("s_valid", 32'(instr_valid), 32'h1);
      chk("s_pc", instr_pc, 32'(c - 3));
      chk("s_instr", instr, 32'(c - 3));
      chk("s_trans", 32'(trans), 32'h3);
    end

    // backpressure
    n_reset     = 1'b0;
    instr_ready = 1'b0;
    step();
    chk("bp_rst_valid", 32'(instr_valid), 32'h0);
    n_reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("bp_req_trans", 32'(trans), (c == 1) ? 32'h2 : 32'h3);
      chk("bp_req_addr", addr, 32'(c - 1));
    end
    for (int c = 5; c <= 6; c++) begin
      step();
      chk("bp_stop_trans", 32'(trans), 32'h0);
      chk("bp_stop_valid", 32'(instr_valid), 32'h1);
      chk("bp_stop_pc", instr_pc, 32'h0);
    end
    step();
    chk("bp_c7_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    step();
    chk("bp_c8_pc", instr_pc, 32'h1);
    chk("bp_c8_trans", 32'(trans), 32'h2);
    chk("bp_c8_addr", addr, 32'h4);
    for (int c = 9; c <= 13; c++) begin
      step();
      chk("bp_pc", instr_pc, 32'(c - 7));
      chk("bp_instr", instr, 32'(c - 7));
      chk("bp_trans", 32'(trans), 32'h3);
    end

    // redirect mid-stream
    branch_valid  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_valid = 1'b0;
    chk("br_k1_valid", 32'(instr_valid), 32'h0);
    chk("br_k1_hold_pc", instr_pc, 32'h6);
    chk("br_k1_trans", 32'(trans), 32'h2);
    chk("br_k1_addr", addr, 32'h100);
    step();
    chk("br_k2_valid", 32'(instr_valid), 32'h0);
    chk("br_k2_trans", 32'(trans), 32'h3);
    chk("br_k2_addr", addr, 32'h101);
    step();
    chk("br_k3_valid", 32'(instr_valid), 32'h1);
    chk("br_k3_pc", instr_pc, 32'h100);
    chk("br_k3_instr", instr, 32'h100);
    step();
    chk("br_k4_pc", instr_pc, 32'h101);

    // abort at address 5
    n_reset    = 1'b0;
    abort_en   = 1'b1;
    abort_addr = 32'h5;
    step();
    n_reset = 1'b1;
    step();
    step();
    for (int c = 3; c <= 8; c++) begin
      step();
      chk("ab_valid", 32'(instr_valid), 32'h1);
      chk("ab_pc", instr_pc, 32'(c - 3));
      chk("ab_flag", 32'(instr_abort), (c == 8) ? 32'h1 : 32'h0);
    end
    chk("ab_c8_trans", 32'(trans), 32'h0);
    for (int c = 9; c <= 11; c++) begin
      step();
      chk("ab_halt_valid", 32'(instr_valid), 32'h0);
      chk("ab_halt_trans", 32'(trans), 32'h0);
      chk("ab_halt_pc", instr_pc, 32'h5);
    end
    abort_en      = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 32'h20;
    step();
    branch_valid = 1'b0;
    chk("ab_rd_trans", 32'(trans), 32'h2);
    chk("ab_rd_addr", addr, 32'h20);
    step();
    step();
    chk("ab_rd_valid", 32'(instr_valid), 32'h1);
    chk("ab_rd_pc", instr_pc, 32'h20);
    chk("ab_rd_flag", 32'(instr_abort), 32'h0);

    // address wrap
    branch_valid  = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    step();
    branch_valid = 1'b0;
    chk("wr_k1_addr", addr, 32'hFFFF_FFFE);
    chk("wr_k1_trans", 32'(trans), 32'h2);
    step();
    chk("wr_k2_addr", addr, 32'hFFFF_FFFF);
    step();
    chk("wr_k3_addr", addr, 32'h0);
    chk("wr_k3_pc", instr_pc, 32'hFFFF_FFFE);
    step();
    chk("wr_k4_pc", instr_pc, 32'hFFFF_FFFF);
    step();
    chk("wr_k5_pc", instr_pc, 32'h0);
    chk("wr_k5_instr", instr, 32'h0);
    step();
    chk("wr_k6_pc", instr_pc, 32'h1);

    // reset with three entries queued
    instr_ready = 1'b0;
    step();
    step();
    chk("mr_pre_valid", 32'(instr_valid), 32'h1);
    chk("mr_pre_pc", instr_pc, 32'h1);
    #1;
    n_reset = 1'b0;
    #1;
    chk("mr_valid", 32'(instr_valid), 32'h0);
    chk("mr_trans", 32'(trans), 32'h0);
    chk("mr_addr", addr, 32'h0);
    chk("mr_pc", instr_pc, 32'h0);
    step();
    instr_ready = 1'b1;
    n_reset     = 1'b1;
    step();
    chk("mr_c1_trans", 32'(trans), 32'h2);
    chk("mr_c1_addr", addr, 32'h0);
    step();
    step();
    chk("mr_c3_valid", 32'(instr_valid), 32'h1);
    chk("mr_c3_pc", instr_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
